dsp_muladd_arbiter: RTL

DSP_MULADD_ARBITER -- requirements
Module: dsp_muladd_arbiter

---
 rtl/dsp_muladd_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dsp_muladd_arbiter.sv
// dsp_muladd_arbiter
//   Two-requester front end for an external fused multiply-add DSP slice
//   (AREG=BREG=MREG=PREG=1, CREG=0). Requests are granted into the DSP,
//   a {valid,id} tag rides alongside the DSP pipeline, and c is delayed so
//   it meets the product at the P-register adder.
//   Optional macro: DSP_ARB_FIXED_PRIORITY_EN -- requester 0 always wins on
//   contention instead of round-robin (RR_INIT then has no effect).
module dsp_muladd_arbiter #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req0_b,
  input  logic [7:0]  req1_b,
  input  logic [15:0] req0_c,
  input  logic [15:0] req1_c,
  output logic [7:0]  dsp_a,
  output logic [7:0]  dsp_b,
  output logic [15:0] dsp_c,
  output logic        dsp_en,
  output logic        dsp_rst,
  input  logic [15:0] dsp_y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_y
);

  localparam logic LP_RR_INIT = (RR_INIT != 0);

  logic        w_stall;
  logic        w_en;
  logic        w_g0;
  logic        w_g1;
  logic        w_gany;
  logic [15:0] w_c_in;

  logic        r_prio;
  logic        r_v1, r_v2, r_v3;
  logic        r_id1, r_id2, r_id3;
  logic [15:0] r_c1, r_c2;

  assign w_stall = r_v3 & ~resp_ready;
  assign w_en    = ~w_stall & ~reset;
  assign w_gany  = w_g0 | w_g1;

  assign dsp_en  = w_en;
  assign dsp_rst = reset;

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  assign resp_valid = r_v3;
  assign resp_id    = r_id3;
  assign resp_y     = dsp_y;

  assign dsp_c = r_v2 ? r_c2 : '0;

  // Grant selection: only when the pipeline can advance and not in reset
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (w_en) begin
      if (req0_valid && req1_valid) begin
`ifdef DSP_ARB_FIXED_PRIORITY_EN
        w_g0 = 1'b1;
`else
        if (r_prio) w_g1 = 1'b1;
        else        w_g0 = 1'b1;
`endif
      end else begin
        w_g0 = req0_valid;
        w_g1 = req1_valid;
      end
    end
  end

  // Operand mux towards the DSP A/B/C inputs; zero when nothing is granted
  always_comb begin
    dsp_a  = '0;
    dsp_b  = '0;
    w_c_in = '0;
    if (w_g0) begin
      dsp_a  = req0_a;
      dsp_b  = req0_b;
      w_c_in = req0_c;
    end else if (w_g1) begin
      dsp_a  = req1_a;
      dsp_b  = req1_b;
      w_c_in = req1_c;
    end
  end

  // Round-robin priority: hand priority to the other requester after a grant
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prio <= LP_RR_INIT;
    end else if (w_gany) begin
      r_prio <= w_g0;
    end
  end

  // Tag pipeline (A, M, P) and c delay line, frozen while stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_id1 <= 1'b0;
      r_id2 <= 1'b0;
      r_id3 <= 1'b0;
      r_c1  <= '0;
      r_c2  <= '0;
    end else if (w_en) begin
      r_v1  <= w_gany;
      r_id1 <= w_g1;
      r_v2  <= r_v1;
      r_id2 <= r_id1;
      r_v3  <= r_v2;
      r_id3 <= r_id2;
      r_c1  <= w_c_in;
      r_c2  <= r_c1;
    end
  end

endmodule
